// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between NUM_REQ requesters.
// Round-robin grant, one transaction in flight. Every request is checked for size,
// alignment and bounds before it reaches memory; illegal ones complete with err and no access.
module dmem_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned DATA_MEM_SIZE = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ-1:0][63:0] req_addr,
    input  logic [NUM_REQ-1:0][63:0] req_wdata,
    input  logic [NUM_REQ-1:0][3:0]  req_size,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     err,
    output logic [63:0]              rdata,
    output logic [63:0]              mem_address,
    output logic                     mem_write_enable,
    output logic                     mem_read_enable,
    output logic [63:0]              mem_write_data,
    output logic [3:0]               mem_xfer_size,
    input  logic [63:0]              mem_read_data
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e               state_q;
    logic [GW-1:0]        last_grant_q;
    logic [GW-1:0]        grant_q;
    logic                 we_q;
    logic [63:0]          addr_q;
    logic [63:0]          wdata_q;
    logic [3:0]           size_q;
    logic                 err_q;
    logic [63:0]          rdata_q;
    logic [NUM_REQ-1:0]   ack_q;

    logic                 any_req;
    logic [GW-1:0]        winner;
    logic [31:0]          cand;
    logic [GW-1:0]        cand_idx;
    logic                 sel_we;
    logic [63:0]          sel_addr;
    logic [63:0]          sel_wdata;
    logic [3:0]           sel_size;
    logic                 size_ok;
    logic                 align_ok;
    logic                 bounds_ok;
    logic                 legal;
    logic [64:0]          end_addr;
    logic [63:0]          rd_mask;
    logic                 in_access;

    // Round-robin pick: scan starting one past the last granted requester.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(last_grant_q) + i + 32'd1;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[GW-1:0];
            if (!any_req && req[cand_idx]) begin
                any_req = 1'b1;
                winner  = cand_idx;
            end
        end
    end

    // Legality check of the winning request; the end address is computed in 65 bits so it cannot wrap.
    always_comb begin
        sel_we    = req_we[winner];
        sel_addr  = req_addr[winner];
        sel_wdata = req_wdata[winner];
        sel_size  = req_size[winner];
        size_ok   = (sel_size == 4'd1) || (sel_size == 4'd2) ||
                    (sel_size == 4'd4) || (sel_size == 4'd8);
        align_ok  = (sel_addr & (64'(sel_size) - 64'd1)) == 64'd0;
        end_addr  = {1'b0, sel_addr} + 65'(sel_size);
        bounds_ok = end_addr <= 65'(DATA_MEM_SIZE);
        legal     = size_ok && align_ok && bounds_ok;
    end

    // Keep only the requested low bytes of read data.
    always_comb begin
        case (size_q)
            4'd1:    rd_mask = 64'h0000_0000_0000_00ff;
            4'd2:    rd_mask = 64'h0000_0000_0000_ffff;
            4'd4:    rd_mask = 64'h0000_0000_ffff_ffff;
            default: rd_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 4'd8;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            ack_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q      <= winner;
                        last_grant_q <= winner;
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        size_q       <= sel_size;
                        if (legal) begin
                            state_q <= StAccess;
                        end else begin
                            // Rejected requests skip the memory and respond next cycle.
                            state_q <= StResp;
                            err_q   <= 1'b1;
                            ack_q   <= OneHot0 << winner;
                        end
                    end
                end
                StAccess: begin
                    rdata_q <= we_q ? 64'd0 : (mem_read_data & rd_mask);
                    ack_q   <= OneHot0 << grant_q;
                    state_q <= StResp;
                end
                StResp: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

    // Memory side: driven only in ACCESS; enables gated by reset so an aborted write never commits.
    always_comb begin
        in_access        = (state_q == StAccess);
        mem_write_enable = in_access && we_q && reset_n;
        mem_read_enable  = in_access && !we_q && reset_n;
        mem_address      = in_access ? addr_q : 64'd0;
        mem_write_data   = in_access ? wdata_q : 64'd0;
        mem_xfer_size    = in_access ? size_q : 4'd8;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned MEM_SIZE = 1024;
    localparam int AW = 10;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ-1:0][63:0] req_addr;
    logic [NUM_REQ-1:0][63:0] req_wdata;
    logic [NUM_REQ-1:0][3:0]  req_size;
    logic [NUM_REQ-1:0]       ack;
    logic                     err;
    logic [63:0]              rdata;
    logic [63:0]              mem_address;
    logic                     mem_write_enable;
    logic                     mem_read_enable;
    logic [63:0]              mem_write_data;
    logic [3:0]               mem_xfer_size;
    logic [63:0]              mem_read_data;

    dmem_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_MEM_SIZE (MEM_SIZE)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_size         (req_size),
        .ack              (ack),
        .err              (err),
        .rdata            (rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .mem_read_data    (mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory attached to the DUT ----------------
    logic [7:0]    mem [MEM_SIZE];
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    int            en_cnt = 0;

    initial begin
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_write_enable || mem_read_enable) en_cnt++;
            if (mem_write_enable) begin
                for (int b = 0; b < 8; b++) begin
                    if (b < int'(mem_xfer_size)) begin
                        wa = mem_address[AW-1:0] + AW'(b);
                        mem[wa] = mem_write_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        mem_read_data = '0;
        ra = '0;
        if (mem_read_enable) begin
            for (int b = 0; b < 8; b++) begin
                ra = mem_address[AW-1:0] + AW'(b);
                mem_read_data[b*8 +: 8] = mem[ra];
            end
        end
    end

    // ---------------- reference model ----------------
    // Timeline view: a legal request accepted at edge E uses memory in cycle E and is acked in
    // cycle E+1; an illegal one is acked in cycle E. The arbiter is free again two cycles after ack.
    logic [7:0]  ref_mem [MEM_SIZE];
    int          cyc = 0;
    bit          p_valid;
    int          p_port;
    bit          p_we;
    bit          p_legal;
    logic [63:0] p_addr;
    logic [63:0] p_wdata;
    logic [63:0] p_rdata;
    logic [3:0]  p_size;
    int          p_acc;
    int          p_ack;
    int          next_free;
    int          m_last;
    int          w;
    int          idx;

    function automatic logic [AW-1:0] aidx(input logic [63:0] a, input int b);
        return a[AW-1:0] + AW'(b);
    endfunction

    function automatic bit is_legal(input logic [63:0] a, input logic [3:0] s);
        int sz;
        sz = int'(s);
        if (!(sz == 1 || sz == 2 || sz == 4 || sz == 8)) return 1'b0;
        if (a % 64'(sz) != 64'd0) return 1'b0;
        return a <= 64'(MEM_SIZE) - 64'(sz);
    endfunction

    initial begin
        p_valid   = 1'b0;
        m_last    = NUM_REQ - 1;
        next_free = 0;
        for (int i = 0; i < int'(MEM_SIZE); i++) ref_mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                p_valid   = 1'b0;
                next_free = cyc + 1;
                m_last    = NUM_REQ - 1;
            end else begin
                if (p_valid && p_legal && p_we && p_acc == cyc - 1) begin
                    for (int b = 0; b < int'(p_size); b++)
                        ref_mem[aidx(p_addr, b)] = p_wdata[b*8 +: 8];
                end
                if (p_valid && cyc > p_ack) p_valid = 1'b0;
                if (cyc >= next_free && req != '0) begin
                    w = -1;
                    for (int k = 1; k <= int'(NUM_REQ); k++) begin
                        idx = (m_last + k) % int'(NUM_REQ);
                        if (w < 0 && req[idx]) w = idx;
                    end
                    p_valid = 1'b1;
                    p_port  = w;
                    p_we    = req_we[w];
                    p_addr  = req_addr[w];
                    p_wdata = req_wdata[w];
                    p_size  = req_size[w];
                    p_legal = is_legal(p_addr, p_size);
                    p_rdata = '0;
                    if (p_legal && !p_we) begin
                        for (int b = 0; b < 8; b++)
                            if (b < int'(p_size)) p_rdata[b*8 +: 8] = ref_mem[aidx(p_addr, b)];
                    end
                    p_acc     = p_legal ? cyc : -1;
                    p_ack     = p_legal ? cyc + 1 : cyc;
                    next_free = p_ack + 2;
                    m_last    = w;
                end
            end
        end
    end

    // ---------------- per-cycle compare and ack log ----------------
    bit chk_en = 1'b0;
    bit in_acc;
    bit in_ack;
    int ack_port_q[$];
    int ack_cyc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                in_acc = p_valid && p_acc == cyc;
                in_ack = p_valid && p_ack == cyc;
                check("cyc_ack", 64'(ack), in_ack ? (64'd1 << p_port) : 64'd0);
                if (in_ack) begin
                    check("cyc_err", 64'(err), 64'(!p_legal));
                    check("cyc_rdata", rdata, p_rdata);
                end
                check("cyc_mem_en", 64'({mem_write_enable, mem_read_enable}),
                      64'({in_acc && p_we && reset_n, in_acc && !p_we && reset_n}));
                check("cyc_mem_addr", mem_address, in_acc ? p_addr : 64'd0);
                check("cyc_mem_wdata", mem_write_data, in_acc ? p_wdata : 64'd0);
                check("cyc_mem_size", 64'(mem_xfer_size), in_acc ? 64'(p_size) : 64'd8);
                for (int p = 0; p < int'(NUM_REQ); p++) begin
                    if (ack[p]) begin
                        ack_port_q.push_back(p);
                        ack_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic txn(input int p, input bit we, input logic [63:0] a, input logic [3:0] s,
                       input logic [63:0] wd, output logic [63:0] rd, output bit e,
                       output int lat);
        @(negedge clk);
        req_we[p]    = we;
        req_addr[p]  = a;
        req_size[p]  = s;
        req_wdata[p] = wd;
        req[p]       = 1'b1;
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (ack[p]) begin
                rd     = rdata;
                e      = err;
                req[p] = 1'b0;
                return;
            end
        end
        req[p] = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL txn_timeout: port %0d got no ack, required ack within 20 cycles", p);
    endtask

    // Keep port p requesting reads back-to-back until n acks arrive.
    task automatic stream(input int p, input int n);
        int got = 0;
        req_we[p]   = 1'b0;
        req_addr[p] = 64'(p * 256);
        req_size[p] = 4'd8;
        req[p]      = 1'b1;
        for (int i = 0; i < 80 && got < n; i++) begin
            @(negedge clk);
            if (ack[p]) begin
                got++;
                req_addr[p] = 64'(p * 256 + got * 8);
                if (got == n) req[p] = 1'b0;
            end
        end
        req[p] = 1'b0;
        check("stream_acks", 64'(got), 64'(n));
    endtask

    logic [63:0] rd;
    bit          e;
    int          lat;
    int          en0;
    int          n0;
    int          exp_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        #1;
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_mem_en", 64'({mem_write_enable, mem_read_enable}), 64'd0);
        check("rst_mem_addr", mem_address, 64'd0);
        check("rst_mem_size", 64'(mem_xfer_size), 64'd8);

        // 1: write then read back a full doubleword.
        txn(0, 1'b1, 64'h10, 4'd8, 64'h1122_3344_5566_7788, rd, e, lat);
        check("t1_wr_err", 64'(e), 64'd0);
        check("t1_wr_lat", 64'(lat), 64'd2);
        txn(0, 1'b0, 64'h10, 4'd8, 64'h0, rd, e, lat);
        check("t1_rd_data", rd, 64'h1122_3344_5566_7788);
        check("t1_rd_err", 64'(e), 64'd0);

        // 3: rejected requests never touch memory and ack one cycle early.
        en0 = en_cnt;
        txn(0, 1'b0, 64'h11, 4'd2, 64'h0, rd, e, lat);
        check("t3_misalign_err", 64'(e), 64'd1);
        check("t3_misalign_lat", 64'(lat), 64'd1);
        txn(1, 1'b0, 64'h3fc, 4'd8, 64'h0, rd, e, lat);
        check("t3_oob_err", 64'(e), 64'd1);
        check("t3_oob_lat", 64'(lat), 64'd1);
        txn(0, 1'b1, 64'h0, 4'd3, 64'h55, rd, e, lat);
        check("t3_badsize_err", 64'(e), 64'd1);
        txn(1, 1'b0, 64'hffff_ffff_ffff_fff8, 4'd8, 64'h0, rd, e, lat);
        check("t3_wrap_err", 64'(e), 64'd1);
        check("t3_no_mem_en", 64'(en_cnt - en0), 64'd0);
        txn(0, 1'b0, 64'h3f8, 4'd8, 64'h0, rd, e, lat);
        check("t3_top_rd_err", 64'(e), 64'd0);
        check("t3_top_rd_data", rd, 64'h0);
        txn(1, 1'b1, 64'h3fc, 4'd4, 64'hdead_beef, rd, e, lat);
        check("t3_top_wr_err", 64'(e), 64'd0);
        txn(0, 1'b0, 64'h3fc, 4'd4, 64'h0, rd, e, lat);
        check("t3_top_rd4", rd, 64'hdead_beef);

        // 4: byte write merges into existing data; narrow reads zero upper bytes.
        txn(1, 1'b1, 64'h0, 4'd8, 64'h0, rd, e, lat);
        txn(1, 1'b1, 64'h5, 4'd1, 64'hab, rd, e, lat);
        txn(0, 1'b0, 64'h0, 4'd8, 64'h0, rd, e, lat);
        check("t4_rd8", rd, 64'h0000_ab00_0000_0000);
        txn(0, 1'b0, 64'h5, 4'd1, 64'h0, rd, e, lat);
        check("t4_rd1", rd, 64'hab);
        txn(1, 1'b1, 64'h40, 4'd8, 64'h0102_0304_0506_0708, rd, e, lat);
        txn(0, 1'b0, 64'h40, 4'd2, 64'h0, rd, e, lat);
        check("t4_rd2_mask", rd, 64'h0708);
        txn(0, 1'b0, 64'h44, 4'd4, 64'h0, rd, e, lat);
        check("t4_rd4_mask", rd, 64'h0102_0304);
        txn(1, 1'b0, 64'h47, 4'd1, 64'h0, rd, e, lat);
        check("t4_rd1_hi", rd, 64'h01);

        // 5: reset during the ACCESS cycle of a write aborts it.
        txn(0, 1'b1, 64'h20, 4'd8, 64'h0123_4567_89ab_cdef, rd, e, lat);
        @(negedge clk);
        req_we[0]    = 1'b1;
        req_addr[0]  = 64'h20;
        req_size[0]  = 4'd1;
        req_wdata[0] = 64'hff;
        req[0]       = 1'b1;
        @(negedge clk);
        check("t5_in_access", 64'(mem_write_enable), 64'd1);
        reset_n = 1'b0;
        req[0]  = 1'b0;
        n0 = ack_port_q.size();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_no_ack", 64'(ack_port_q.size() - n0), 64'd0);
        txn(1, 1'b0, 64'h20, 4'd8, 64'h0, rd, e, lat);
        check("t5_prior_data", rd, 64'h0123_4567_89ab_cdef);

        // 2: both ports requesting from reset alternate strictly.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        ack_port_q.delete();
        ack_cyc_q.delete();
        fork
            stream(0, 4);
            stream(1, 4);
            begin
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        @(negedge clk);
        check("t2_count", 64'(ack_port_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < ack_port_q.size()) check("t2_order", 64'(ack_port_q[i]), 64'(exp_order[i]));
            if (i + 1 < ack_cyc_q.size())
                check("t2_spacing", 64'(ack_cyc_q[i+1] - ack_cyc_q[i]), 64'd3);
        end

        // 6: a single port holding req is serviced every third cycle.
        ack_port_q.delete();
        ack_cyc_q.delete();
        @(negedge clk);
        req_we[0]   = 1'b0;
        req_addr[0] = 64'h10;
        req_size[0] = 4'd8;
        req[0]      = 1'b1;
        for (int i = 0; i < 40 && ack_cyc_q.size() < 3; i++) @(negedge clk);
        req[0] = 1'b0;
        check("t6_count", 64'(ack_cyc_q.size()), 64'd3);
        for (int i = 0; i + 1 < ack_cyc_q.size(); i++)
            check("t6_spacing", 64'(ack_cyc_q[i+1] - ack_cyc_q[i]), 64'd3);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
